z80_io_write_capture: RTL and testbench

- Front-end stage between the Z80 host bus and the I/O register bank.
- Synchronises the asynchronous Z80 I/O-write bus cycle into the GPU clock domain and qualifies it as a stable, genuine write.
- Captures the data byte into a 256-entry port data array and emits a single-cycle strobe on the bit of the addressed port.
- Drives the port data array and strobe vector consumed by the I/O register bank (MMU, SD, PSG, RNG, GPU MMU ports).

---
 rtl/z80_io_write_capture.sv | 171 +++++++++++++++++
 tb/tb_z80_io_write_capture.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_write_capture.sv
`default_nettype none
// ============================================================================
// Module   : z80_io_write_capture
// Purpose  : Synchronises and qualifies Z80 I/O write cycles, captures the byte
//            into a 256-port data array and pulses a one-hot per-port strobe.
//            Optional readback port enabled by macro Z80_IO_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module z80_io_write_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int QUAL_CYCLES = 3
) (
    input  logic         clk,
    input  logic         reset,
`ifdef Z80_IO_READBACK_EN
    input  logic [7:0]   rd_port,
    output logic [7:0]   rd_data,
`endif
    input  logic         z80_IORQn,
    input  logic         z80_WRn,
    input  logic         z80_M1n,
    input  logic [7:0]   z80_addr,
    input  logic [7:0]   z80_data,
    output logic [7:0]   WRITE_PORT_DATA [0:255],
    output logic [255:0] WRITE_PORT_STROBE,
    output logic         wr_busy,
    output logic [15:0]  wr_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUALIFY = 2'd1,
        S_STROBE  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // Bus vector layout: {M1n, WRn, IORQn, addr, data}; idle = strobes high.
    localparam logic [18:0] c_BUS_IDLE  = {1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
    localparam logic [3:0]  c_QUAL_LAST = 4'(QUAL_CYCLES);

    logic [18:0] r_sync [SYNC_STAGES];
    logic        w_iorqn_s;
    logic        w_wrn_s;
    logic        w_m1n_s;
    logic [7:0]  w_addr_s;
    logic [7:0]  w_data_s;
    logic        w_wr_cond;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_qual_cnt;
    logic [3:0]  w_qual_cnt_nxt;
    logic [7:0]  r_addr_q;
    logic [7:0]  w_addr_q_nxt;
    logic [7:0]  r_data_q;
    logic [7:0]  w_data_q_nxt;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= c_BUS_IDLE;
            end
        end else begin
            r_sync[0] <= {z80_M1n, z80_WRn, z80_IORQn, z80_addr, z80_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign {w_m1n_s, w_wrn_s, w_iorqn_s, w_addr_s, w_data_s} = r_sync[SYNC_STAGES-1];
    // M1n low alongside IORQn is an interrupt acknowledge, never a write.
    assign w_wr_cond = !w_iorqn_s && !w_wrn_s && w_m1n_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_qual_cnt <= 4'd0;
            r_addr_q   <= 8'h00;
            r_data_q   <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_qual_cnt <= w_qual_cnt_nxt;
            r_addr_q   <= w_addr_q_nxt;
            r_data_q   <= w_data_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_qual_cnt_nxt = r_qual_cnt;
        w_addr_q_nxt   = r_addr_q;
        w_data_q_nxt   = r_data_q;
        unique case (r_state)
            S_IDLE: begin
                if (w_wr_cond) begin
                    w_addr_q_nxt   = w_addr_s;
                    w_qual_cnt_nxt = 4'd1;
                    if (c_QUAL_LAST == 4'd1) begin
                        w_data_q_nxt = w_data_s;
                        w_state_nxt  = S_STROBE;
                    end else begin
                        w_state_nxt  = S_QUALIFY;
                    end
                end
            end
            S_QUALIFY: begin
                if (!w_wr_cond) begin
                    w_state_nxt = S_IDLE;
                end else if (w_addr_s != r_addr_q) begin
                    // A moving address restarts qualification on the new port.
                    w_addr_q_nxt   = w_addr_s;
                    w_qual_cnt_nxt = 4'd1;
                end else begin
                    w_qual_cnt_nxt = r_qual_cnt + 4'd1;
                    if (w_qual_cnt_nxt == c_QUAL_LAST) begin
                        w_data_q_nxt = w_data_s;
                        w_state_nxt  = S_STROBE;
                    end
                end
            end
            S_STROBE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_iorqn_s && w_wrn_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Data and strobe are registered together so they become valid in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                WRITE_PORT_DATA[i] <= 8'h00;
            end
            WRITE_PORT_STROBE <= '0;
            r_wr_count        <= 16'h0000;
        end else begin
            WRITE_PORT_STROBE <= '0;
            if (r_state == S_STROBE) begin
                WRITE_PORT_DATA[r_addr_q]   <= r_data_q;
                WRITE_PORT_STROBE[r_addr_q] <= 1'b1;
                r_wr_count                  <= r_wr_count + 16'h0001;
            end
        end
    end

    assign wr_count = r_wr_count;
    assign wr_busy  = (r_state != S_IDLE);

`ifdef Z80_IO_READBACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= 8'h00;
        end else if ((r_state == S_STROBE) && (r_addr_q == rd_port)) begin
            rd_data <= r_data_q;
        end else begin
            rd_data <= WRITE_PORT_DATA[rd_port];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_z80_io_write_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_io_write_capture
// Purpose  : Scoreboard bench for z80_io_write_capture (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_io_write_capture;

    localparam int c_LATENCY = 6;

    logic         clk;
    logic         reset;
    logic         z80_IORQn;
    logic         z80_WRn;
    logic         z80_M1n;
    logic [7:0]   z80_addr;
    logic [7:0]   z80_data;
    logic [7:0]   port_data [0:255];
    logic [255:0] port_strobe;
    logic         wr_busy;
    logic [15:0]  wr_count;
`ifdef Z80_IO_READBACK_EN
    logic [7:0]   rd_port;
    logic [7:0]   rd_data;
`endif

    z80_io_write_capture #(
        .SYNC_STAGES(2),
        .QUAL_CYCLES(3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef Z80_IO_READBACK_EN
        .rd_port          (rd_port),
        .rd_data          (rd_data),
`endif
        .z80_IORQn        (z80_IORQn),
        .z80_WRn          (z80_WRn),
        .z80_M1n          (z80_M1n),
        .z80_addr         (z80_addr),
        .z80_data         (z80_data),
        .WRITE_PORT_DATA  (port_data),
        .WRITE_PORT_STROBE(port_strobe),
        .wr_busy          (wr_busy),
        .wr_count         (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  port;
        logic [7:0]  data;
        logic [15:0] count;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors;
    int          checks;
    int          cyc;
    logic [15:0] exp_count;

    // Advances n cycles; every strobe seen at a falling edge is matched against the scoreboard.
    task automatic step(input int n);
        exp_t e;
        int   p;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (port_strobe != '0) begin
                p = 0;
                for (int i = 0; i < 256; i++) if (port_strobe[i]) p = i;
                checks++;
                if ($countones(port_strobe) != 1) begin
                    errors++;
                    $display("FAIL strobe_onehot: %0d bits set, required 1", $countones(port_strobe));
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: port %02h at cycle %0d, required none", p, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checks += 4;
                    if (8'(p) !== e.port) begin
                        errors++;
                        $display("FAIL strobe_port: got %02h, required %02h", p, e.port);
                    end
                    if (port_data[p] !== e.data) begin
                        errors++;
                        $display("FAIL strobe_data: got %02h, required %02h", port_data[p], e.data);
                    end
                    if (wr_count !== e.count) begin
                        errors++;
                        $display("FAIL strobe_count: got %04h, required %04h", wr_count, e.count);
                    end
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL strobe_latency: cycle %0d, required %0d", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        z80_addr  = a;
        z80_data  = d;
        z80_M1n   = 1'b1;
        z80_IORQn = 1'b0;
        z80_WRn   = 1'b0;
    endtask

    task automatic bus_idle();
        z80_IORQn = 1'b1;
        z80_WRn   = 1'b1;
        z80_M1n   = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] d, input int delay);
        exp_t e;
        exp_count = exp_count + 16'h0001;
        e.port  = a;
        e.data  = d;
        e.count = exp_count;
        e.cyc   = cyc + delay;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int nz;
        reset = 1'b0;
        bus_idle();
        z80_addr = 8'h00;
        z80_data = 8'h00;
        step(3);
        nz = 0;
        for (int i = 0; i < 256; i++) if (port_data[i] !== 8'h00) nz++;
        checks += 4;
        if (nz != 0) begin errors++; $display("FAIL reset_data: %0d nonzero entries, required 0", nz); end
        if (port_strobe !== '0) begin errors++; $display("FAIL reset_strobe: got nonzero, required 0"); end
        if (wr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", wr_busy); end
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %04h, required 0000", wr_count); end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_basic_write();
        bus_write(8'h38, 8'h5A);
        push_exp(8'h38, 8'h5A, c_LATENCY);
        step(20);
        checks++;
        if (wr_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %b, required 1", wr_busy); end
        bus_idle();
        step(6);
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing_strobe: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        if (port_data[8'h38] !== 8'h5A) begin errors++; $display("FAIL basic_data: got %02h, required 5a", port_data[8'h38]); end
        if (wr_count !== 16'h0001) begin errors++; $display("FAIL basic_count: got %04h, required 0001", wr_count); end
        if (wr_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_release: got %b, required 0", wr_busy); end
`ifdef Z80_IO_READBACK_EN
        rd_port = 8'h38;
        step(1);
        checks++;
        if (rd_data !== 8'h5A) begin errors++; $display("FAIL readback: got %02h, required 5a", rd_data); end
`endif
    endtask

    task automatic test_glitch();
        bus_write(8'hF2, 8'hC3);
        step(2);
        bus_idle();
        step(1);
        checks++;
        if (wr_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b, required 1", wr_busy); end
        step(8);
        checks += 3;
        if (port_data[8'hF2] !== 8'h00) begin errors++; $display("FAIL glitch_data: got %02h, required 00", port_data[8'hF2]); end
        if (wr_count !== exp_count) begin errors++; $display("FAIL glitch_count: got %04h, required %04h", wr_count, exp_count); end
        if (wr_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b, required 0", wr_busy); end
    endtask

    task automatic test_intack_and_read();
        bus_write(8'h10, 8'h99);
        z80_M1n = 1'b0;
        step(10);
        checks++;
        if (wr_busy !== 1'b0) begin errors++; $display("FAIL intack_busy: got %b, required 0", wr_busy); end
        bus_idle();
        step(4);
        z80_addr  = 8'hF0;
        z80_data  = 8'h77;
        z80_IORQn = 1'b0;
        step(10);
        checks++;
        if (wr_busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %b, required 0", wr_busy); end
        bus_idle();
        step(4);
        checks += 3;
        if (port_data[8'h10] !== 8'h00) begin errors++; $display("FAIL intack_data: got %02h, required 00", port_data[8'h10]); end
        if (port_data[8'hF0] !== 8'h00) begin errors++; $display("FAIL read_data: got %02h, required 00", port_data[8'hF0]); end
        if (wr_count !== exp_count) begin errors++; $display("FAIL intack_count: got %04h, required %04h", wr_count, exp_count); end
    endtask

    task automatic test_addr_change();
        bus_write(8'hFC, 8'h12);
        step(1);
        z80_addr = 8'hFD;
        push_exp(8'hFD, 8'h12, c_LATENCY);
        step(12);
        bus_idle();
        step(6);
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL addr_missing_strobe: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        if (port_data[8'hFD] !== 8'h12) begin errors++; $display("FAIL addr_new_data: got %02h, required 12", port_data[8'hFD]); end
        if (port_data[8'hFC] !== 8'h00) begin errors++; $display("FAIL addr_old_data: got %02h, required 00", port_data[8'hFC]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int n = 1; n <= 4; n++) begin
            d = 8'(n);
            bus_write(8'hF1, d);
            push_exp(8'hF1, d, c_LATENCY);
            step(8);
            bus_idle();
            step(4);
        end
        step(4);
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_strobe: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        if (port_data[8'hF1] !== 8'h04) begin errors++; $display("FAIL b2b_data: got %02h, required 04", port_data[8'hF1]); end
        if (wr_count !== exp_count) begin errors++; $display("FAIL b2b_count: got %04h, required %04h", wr_count, exp_count); end
        if (port_data[8'h38] !== 8'h5A) begin errors++; $display("FAIL retain_data: got %02h, required 5a", port_data[8'h38]); end
    endtask

    task automatic test_count_wrap();
        force dut.r_wr_count = 16'hFFFF;
        #1;
        release dut.r_wr_count;
        exp_count = 16'hFFFF;
        step(1);
        checks++;
        if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %04h, required ffff", wr_count); end
        bus_write(8'h55, 8'hA5);
        push_exp(8'h55, 8'hA5, c_LATENCY);
        step(10);
        bus_idle();
        step(6);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing_strobe: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %04h, required 0000", wr_count); end
    endtask

    task automatic test_reset_mid_write();
        int nz;
        bus_write(8'hF1, 8'hEE);
        step(4);
        reset = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < 256; i++) if (port_data[i] !== 8'h00) nz++;
        checks += 4;
        if (nz != 0) begin errors++; $display("FAIL midrst_data: %0d nonzero entries, required 0", nz); end
        if (port_strobe !== '0) begin errors++; $display("FAIL midrst_strobe: got nonzero, required 0"); end
        if (wr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", wr_busy); end
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL midrst_count: got %04h, required 0000", wr_count); end
        exp_count = 16'h0000;
        step(3);
        // Bus is still driving a write: after release it must be taken as a fresh cycle.
        reset = 1'b1;
        push_exp(8'hF1, 8'hEE, c_LATENCY);
        step(10);
        bus_idle();
        step(6);
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_missing_strobe: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        if (port_data[8'hF1] !== 8'hEE) begin errors++; $display("FAIL midrst_fresh_data: got %02h, required ee", port_data[8'hF1]); end
        if (wr_count !== 16'h0001) begin errors++; $display("FAIL midrst_fresh_count: got %04h, required 0001", wr_count); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        exp_count = 16'h0000;
`ifdef Z80_IO_READBACK_EN
        rd_port   = 8'h00;
`endif
        test_reset();
        test_basic_write();
        test_glitch();
        test_intack_and_read();
        test_addr_change();
        test_back_to_back();
        test_count_wrap();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
